// File: rtl/ariane_pkg.sv
// Shared frontend types: branch-history update requests and table write commands.
// Row/column widths are sized for the default 1024-entry BHT.
package ariane_pkg;

    localparam int unsigned VLEN            = 64;
    localparam int unsigned INSTR_PER_FETCH = 2;
    localparam int unsigned BHT_NR_ENTRIES  = 1024;
    localparam int unsigned BHT_ROW_W       = $clog2(BHT_NR_ENTRIES / INSTR_PER_FETCH);
    localparam int unsigned BHT_COL_W       = (INSTR_PER_FETCH > 1) ? $clog2(INSTR_PER_FETCH) : 1;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic            taken;
    } bht_update_t;

    // all_cols marks a flush write that clears every column of the row at once.
    typedef struct packed {
        logic                 valid;
        logic [BHT_ROW_W-1:0] row;
        logic [BHT_COL_W-1:0] col;
        logic                 set_valid;
        logic                 all_cols;
        logic                 taken;
    } bht_wr_t;

    typedef enum logic {
        BHT_RUN,
        BHT_FLUSH
    } bht_state_e;

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO; a push is accepted while full if the head is popped in the same cycle.
// DEPTH must be a power of two and at least 2.
module fifo_v3 #(
    parameter int unsigned DEPTH = 4,
    parameter type         dtype = logic [7:0]
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic flush_i,
    output logic full_o,
    output logic empty_o,
    input  dtype data_i,
    input  logic push_i,
    output dtype data_o,
    input  logic pop_i
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    dtype              mem_q [DEPTH];
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/bht_update_ctrl.sv
// Serialises primary and buffered secondary BHT updates into one registered write port,
// with a row-by-row table flush and a starvation guard for the secondary buffer.
module bht_update_ctrl
    import ariane_pkg::*;
#(
    parameter int unsigned NR_ENTRIES   = 1024,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_req_i,
    input  logic        debug_mode_i,
    input  bht_update_t pri_i,
    output logic        pri_ready_o,
    input  bht_update_t sec_i,
    output logic        sec_ready_o,
    output bht_wr_t     wr_o,
    output logic        busy_o,
    output logic        flush_done_o
);

    localparam int unsigned NR_ROWS         = NR_ENTRIES / INSTR_PER_FETCH;
    localparam int unsigned ROW_W           = $clog2(NR_ROWS);
    localparam int unsigned ROW_ADDR_BITS   = $clog2(INSTR_PER_FETCH);
    localparam int unsigned PREDICTION_BITS = ROW_W + ROW_ADDR_BITS + 1;
    localparam int unsigned STARVE_W        = $clog2(STARVE_LIMIT + 1);

    bht_state_e          state_q, state_d;
    logic [ROW_W-1:0]    cnt_q, cnt_d, flush_row;
    logic [STARVE_W-1:0] starve_q, starve_d;
    bht_wr_t             wr_d, wr_p1;
    logic                done_d, flush_done_p1;
    logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic                force_head;
    bht_update_t         fifo_head;

    function automatic bht_wr_t issue_wr(input bht_update_t u);
        bht_wr_t w;
        w           = '0;
        w.valid     = 1'b1;
        w.row       = BHT_ROW_W'(u.pc[PREDICTION_BITS-1:ROW_ADDR_BITS+1]);
        w.col       = BHT_COL_W'(u.pc[ROW_ADDR_BITS:1]);
        w.set_valid = 1'b1;
        w.taken     = u.taken;
        return w;
    endfunction

    fifo_v3 #(
        .DEPTH (FIFO_DEPTH),
        .dtype (bht_update_t)
    ) i_sec_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_req_i),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .data_i  (sec_i),
        .push_i  (fifo_push),
        .data_o  (fifo_head),
        .pop_i   (fifo_pop)
    );

    assign force_head = (starve_q >= STARVE_W'(STARVE_LIMIT)) && !fifo_empty;
    // A re-request mid-flush makes the current cycle clear row 0 again.
    assign flush_row  = flush_req_i ? '0 : cnt_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        wr_d        = '0;
        done_d      = 1'b0;
        fifo_push   = 1'b0;
        fifo_pop    = 1'b0;
        pri_ready_o = 1'b1;
        sec_ready_o = 1'b1;
        unique case (state_q)
            BHT_RUN: begin
                pri_ready_o = !force_head;
                if (flush_req_i) begin
                    state_d  = BHT_FLUSH;
                    cnt_d    = '0;
                    starve_d = '0;
                end else if (!debug_mode_i) begin
                    if (pri_i.valid && !force_head) begin
                        wr_d = issue_wr(pri_i);
                    end else if (!fifo_empty) begin
                        wr_d     = issue_wr(fifo_head);
                        fifo_pop = 1'b1;
                    end
                    fifo_push = sec_i.valid;
                    if (fifo_pop || fifo_empty) begin
                        starve_d = '0;
                    end else if (wr_d.valid) begin
                        starve_d = starve_q + 1'b1;
                    end
                end
                sec_ready_o = !fifo_full || fifo_pop;
            end
            BHT_FLUSH: begin
                wr_d.valid    = 1'b1;
                wr_d.row      = BHT_ROW_W'(flush_row);
                wr_d.all_cols = 1'b1;
                cnt_d         = flush_row + 1'b1;
                if (!flush_req_i && cnt_q == ROW_W'(NR_ROWS - 1)) begin
                    state_d = BHT_RUN;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    // ---- stage p1: registered write command and flush status ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= BHT_RUN;
            cnt_q         <= '0;
            starve_q      <= '0;
            wr_p1         <= '0;
            flush_done_p1 <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            starve_q      <= starve_d;
            wr_p1         <= wr_d;
            flush_done_p1 <= done_d;
        end
    end

    assign wr_o         = wr_p1;
    assign busy_o       = (state_q == BHT_FLUSH);
    assign flush_done_o = flush_done_p1;

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Directed bench for bht_update_ctrl with the default 1024-entry, 2-wide configuration
// (row = pc[10:2], col = pc[1]).
module tb_bht_update_ctrl;
    import ariane_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i, flush_req_i, debug_mode_i;
    bht_update_t pri_i, sec_i;
    logic        pri_ready_o, sec_ready_o, busy_o, flush_done_o;
    bht_wr_t     wr_o;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bht_update_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .flush_req_i  (flush_req_i),
        .debug_mode_i (debug_mode_i),
        .pri_i        (pri_i),
        .pri_ready_o  (pri_ready_o),
        .sec_i        (sec_i),
        .sec_ready_o  (sec_ready_o),
        .wr_o         (wr_o),
        .busy_o       (busy_o),
        .flush_done_o (flush_done_o)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        flush_req_i  = 1'b0;
        debug_mode_i = 1'b0;
        pri_i        = '0;
        sec_i        = '0;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        idle_inputs();
        repeat (2) tick();
        rst_i = 1'b0;
        vectors++;
        if (wr_o !== '0) begin
            miscompares++; $display("FAIL reset_wr: got %h want 0", wr_o);
        end
        vectors++;
        if (busy_o !== 1'b0) begin
            miscompares++; $display("FAIL reset_busy: got %b want 0", busy_o);
        end
        vectors++;
        if (flush_done_o !== 1'b0) begin
            miscompares++; $display("FAIL reset_done: got %b want 0", flush_done_o);
        end
        vectors++;
        if (pri_ready_o !== 1'b1) begin
            miscompares++; $display("FAIL reset_pri_ready: got %b want 1", pri_ready_o);
        end
        vectors++;
        if (sec_ready_o !== 1'b1) begin
            miscompares++; $display("FAIL reset_sec_ready: got %b want 1", sec_ready_o);
        end
    endtask

    task automatic test_primary;
        logic [15:0] pcs   [4] = '{16'h0804, 16'h0806, 16'h07FE, 16'h0000};
        logic        tks   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [8:0]  rows  [4] = '{9'h001, 9'h001, 9'h1FF, 9'h000};
        logic        cols  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        bht_wr_t     exp;
        for (int k = 0; k < 4; k++) begin
            pri_i       = '0;
            pri_i.valid = 1'b1;
            pri_i.pc    = 64'(pcs[k]);
            pri_i.taken = tks[k];
            #1;
            vectors++;
            if (pri_ready_o !== 1'b1) begin
                miscompares++; $display("FAIL pri_ready[%0d]: got %b want 1", k, pri_ready_o);
            end
            tick();
            exp = '0; exp.valid = 1'b1; exp.row = rows[k]; exp.col = cols[k];
            exp.set_valid = 1'b1; exp.taken = tks[k];
            vectors++;
            if (wr_o !== exp) begin
                miscompares++; $display("FAIL pri_wr[%0d]: got %h want %h", k, wr_o, exp);
            end
        end
        pri_i = '0;
        tick();
        vectors++;
        if (wr_o.valid !== 1'b0) begin
            miscompares++; $display("FAIL pri_idle: got valid %b want 0", wr_o.valid);
        end
    endtask

    task automatic test_flush;
        bht_wr_t exp;
        flush_req_i = 1'b1;
        tick();
        flush_req_i = 1'b0;
        vectors++;
        if (wr_o.valid !== 1'b0) begin
            miscompares++; $display("FAIL flush_req_cycle_wr: got valid %b want 0", wr_o.valid);
        end
        // Updates offered throughout the flush must be accepted and dropped.
        pri_i = '0; pri_i.valid = 1'b1; pri_i.pc = 64'h0104; pri_i.taken = 1'b1;
        sec_i = '0; sec_i.valid = 1'b1; sec_i.pc = 64'h0208;
        for (int i = 0; i < 512; i++) begin
            #1;
            vectors++;
            if ({busy_o, flush_done_o, pri_ready_o, sec_ready_o} !== 4'b1011) begin
                miscompares++;
                $display("FAIL flush_status[%0d]: got busy/done/prdy/srdy %b%b%b%b want 1011",
                         i, busy_o, flush_done_o, pri_ready_o, sec_ready_o);
            end
            tick();
            exp = '0; exp.valid = 1'b1; exp.row = 9'(i); exp.all_cols = 1'b1;
            vectors++;
            if (wr_o !== exp) begin
                miscompares++; $display("FAIL flush_wr[%0d]: got %h want %h", i, wr_o, exp);
            end
        end
        pri_i = '0;
        sec_i = '0;
        vectors++;
        if ({busy_o, flush_done_o} !== 2'b01) begin
            miscompares++; $display("FAIL flush_end: got busy/done %b%b want 01", busy_o, flush_done_o);
        end
        tick();
        vectors++;
        if ({flush_done_o, wr_o.valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL flush_after: got done/wr_valid %b%b want 00", flush_done_o, wr_o.valid);
        end
    endtask

    task automatic test_flush_restart;
        int busy_cnt = 0;
        int done_cnt = 0;
        flush_req_i = 1'b1;
        tick();
        flush_req_i = 1'b0;
        for (int c = 0; c < 2000 && done_cnt == 0; c++) begin
            if (busy_o) busy_cnt++;
            if (flush_done_o) done_cnt++;
            flush_req_i = busy_o && (busy_cnt == 101);
            tick();
            if (busy_cnt == 101) begin
                vectors++;
                if (wr_o.row !== 9'h000 || wr_o.valid !== 1'b1) begin
                    miscompares++; $display("FAIL restart_row: got %h want row 000", wr_o);
                end
            end
        end
        flush_req_i = 1'b0;
        vectors++;
        if (busy_cnt !== 612) begin
            miscompares++; $display("FAIL restart_busy_cycles: got %0d want 612", busy_cnt);
        end
        vectors++;
        if (done_cnt !== 1) begin
            miscompares++; $display("FAIL restart_done_count: got %0d want 1", done_cnt);
        end
        vectors++;
        if ({busy_o, flush_done_o} !== 2'b00) begin
            miscompares++; $display("FAIL restart_after: got busy/done %b%b want 00", busy_o, flush_done_o);
        end
    endtask

    task automatic test_starvation;
        bht_wr_t exp;
        for (int c = 0; c < 7; c++) begin
            pri_i = '0; pri_i.valid = 1'b1; pri_i.taken = 1'b1;
            pri_i.pc = 64'(16'h0100 + 4 * ((c == 6) ? 5 : c));
            sec_i = '0;
            if (c == 0) begin
                sec_i.valid = 1'b1; sec_i.pc = 64'h020A;
            end
            #1;
            vectors++;
            if (pri_ready_o !== (c != 5)) begin
                miscompares++; $display("FAIL starve_pri_ready[%0d]: got %b want %b", c, pri_ready_o, c != 5);
            end
            tick();
            exp = '0; exp.valid = 1'b1; exp.set_valid = 1'b1;
            if (c == 5) begin
                exp.row = 9'h082; exp.col = 1'b1; exp.taken = 1'b0;
            end else begin
                exp.row = 9'h040 + 9'((c == 6) ? 5 : c); exp.taken = 1'b1;
            end
            vectors++;
            if (wr_o !== exp) begin
                miscompares++; $display("FAIL starve_wr[%0d]: got %h want %h", c, wr_o, exp);
            end
        end
        pri_i = '0;
        sec_i = '0;
        tick();
    endtask

    typedef struct packed {
        logic        pv;
        logic [15:0] ppc;
        logic        sv;
        logic [15:0] spc;
        logic        epr;
        logic        esr;
        logic        ev;
        logic [8:0]  erow;
        logic        ecol;
        logic        etk;
    } vec_t;

    task automatic test_back_to_back;
        vec_t    tbl [20];
        bht_wr_t exp;
        // full FIFO under primary pressure, then drain
        tbl[0]  = '{1'b1, 16'h0040, 1'b1, 16'h0402, 1'b1, 1'b1, 1'b1, 9'h010, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 16'h0044, 1'b1, 16'h0406, 1'b1, 1'b1, 1'b1, 9'h011, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 16'h0048, 1'b1, 16'h040A, 1'b1, 1'b1, 1'b1, 9'h012, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 16'h004C, 1'b1, 16'h040E, 1'b1, 1'b1, 1'b1, 9'h013, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 16'h0050, 1'b1, 16'h0412, 1'b1, 1'b0, 1'b1, 9'h014, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 16'h0054, 1'b1, 16'h0412, 1'b0, 1'b1, 1'b1, 9'h100, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 9'h101, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 9'h102, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 9'h103, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 9'h104, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0};
        // secondary-only burst of five
        tbl[11] = '{1'b0, 16'h0000, 1'b1, 16'h0602, 1'b1, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 16'h0000, 1'b1, 16'h0606, 1'b1, 1'b1, 1'b1, 9'h180, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 16'h0000, 1'b1, 16'h060A, 1'b1, 1'b1, 1'b1, 9'h181, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 16'h0000, 1'b1, 16'h060E, 1'b1, 1'b1, 1'b1, 9'h182, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 16'h0000, 1'b1, 16'h0612, 1'b1, 1'b1, 1'b1, 9'h183, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 9'h184, 1'b1, 1'b0};
        // same row/col from both ports: two separate writes, primary first
        tbl[17] = '{1'b1, 16'h0804, 1'b1, 16'h0804, 1'b1, 1'b1, 1'b1, 9'h001, 1'b0, 1'b1};
        tbl[18] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 9'h001, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0};
        for (int c = 0; c < 20; c++) begin
            pri_i = '0; pri_i.valid = tbl[c].pv; pri_i.pc = 64'(tbl[c].ppc); pri_i.taken = 1'b1;
            sec_i = '0; sec_i.valid = tbl[c].sv; sec_i.pc = 64'(tbl[c].spc); sec_i.taken = 1'b0;
            #1;
            vectors++;
            if ({pri_ready_o, sec_ready_o} !== {tbl[c].epr, tbl[c].esr}) begin
                miscompares++;
                $display("FAIL b2b_ready[%0d]: got pri/sec %b%b want %b%b",
                         c, pri_ready_o, sec_ready_o, tbl[c].epr, tbl[c].esr);
            end
            tick();
            exp = '0;
            if (tbl[c].ev) begin
                exp.valid = 1'b1; exp.row = tbl[c].erow; exp.col = tbl[c].ecol;
                exp.set_valid = 1'b1; exp.taken = tbl[c].etk;
            end
            vectors++;
            if (wr_o !== exp) begin
                miscompares++; $display("FAIL b2b_wr[%0d]: got %h want %h", c, wr_o, exp);
            end
        end
        pri_i = '0;
        sec_i = '0;
    endtask

    task automatic test_debug_and_abort;
        debug_mode_i = 1'b1;
        pri_i = '0; pri_i.valid = 1'b1; pri_i.pc = 64'h0010; pri_i.taken = 1'b1;
        sec_i = '0; sec_i.valid = 1'b1; sec_i.pc = 64'h0020;
        #1;
        vectors++;
        if ({pri_ready_o, sec_ready_o} !== 2'b11) begin
            miscompares++; $display("FAIL dbg_ready: got pri/sec %b%b want 11", pri_ready_o, sec_ready_o);
        end
        tick();
        vectors++;
        if (wr_o.valid !== 1'b0) begin
            miscompares++; $display("FAIL dbg_wr: got valid %b want 0", wr_o.valid);
        end
        debug_mode_i = 1'b0;
        pri_i = '0;
        sec_i = '0;
        tick();
        vectors++;
        if (wr_o.valid !== 1'b0) begin
            miscompares++; $display("FAIL dbg_no_push: got valid %b want 0", wr_o.valid);
        end
        debug_mode_i = 1'b1;
        flush_req_i  = 1'b1;
        tick();
        flush_req_i  = 1'b0;
        vectors++;
        if (busy_o !== 1'b1) begin
            miscompares++; $display("FAIL dbg_flush_busy: got %b want 1", busy_o);
        end
        repeat (20) tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        debug_mode_i = 1'b0;
        vectors++;
        if ({busy_o, flush_done_o} !== 2'b00 || wr_o !== '0) begin
            miscompares++;
            $display("FAIL abort_state: got busy/done %b%b wr %h want 00 wr 0", busy_o, flush_done_o, wr_o);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if ({busy_o, flush_done_o} !== 2'b00) begin
                miscompares++; $display("FAIL abort_no_done[%0d]: got busy/done %b%b want 00", c, busy_o, flush_done_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_primary();
        test_flush();
        test_flush_restart();
        test_starvation();
        test_back_to_back();
        test_debug_and_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
